hilo_div_ctrl: RTL and testbench

HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

---
 rtl/hilo_div_ctrl_pkg.sv | 32 +++
 rtl/hilo_div_ctrl_if.sv | 58 +++++
 rtl/hilo_div_ctrl_hilo_reg.sv | 44 ++++
 rtl/hilo_div_ctrl.sv | 129 ++++++++++++
 tb/tb_hilo_div_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hilo_div_ctrl_pkg
//   Shared definitions for the HI/LO divide controller slice:
//     - md_op_e     : EX-stage HI/LO operation encodings
//     - div_state_e : controller FSM state encodings
//     - DATA_W/RES_W: operand width and divider result width
//     - is_div_op() : true for the two opcodes that start the divider
// ---------------------------------------------------------------------------
package hilo_div_ctrl_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned RES_W  = 64;

   typedef enum logic [2:0] {
      MD_NONE = 3'd0,
      MD_DIV  = 3'd1,
      MD_DIVU = 3'd2,
      MD_MTHI = 3'd3,
      MD_MTLO = 3'd4
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// ---------------------------------------------------------------------------
// hilo_div_ctrl_if
//   Bundles the EX-stage request, the divider handshake and the HI/LO
//   outputs of hilo_div_ctrl.
//
//   Handshake: an EX request is taken only in IDLE, when ex_valid_i=1,
//   flush_i=0 and the op is DIV/DIVU/MTHI/MTLO. A divide holds div_start_o
//   high until the divider answers with div_ready_i=1 (result on
//   div_result_i in that same cycle); dropping div_start_o frees the
//   divider, and div_annul_o=1 tells it to throw away a divide in flight.
//
//   Modports:
//     slave  - the controller (consumes EX/divider inputs, drives outputs)
//     master - the environment (pipeline + divider)
//   dbg_state_o exposes the controller FSM state for observation only.
// ---------------------------------------------------------------------------
interface hilo_div_ctrl_if;
   import hilo_div_ctrl_pkg::*;

   // EX stage side
   logic                ex_valid_i;
   logic [2:0]          ex_op_i;
   logic [DATA_W-1:0]   opdata1_i;
   logic [DATA_W-1:0]   opdata2_i;
   logic                flush_i;

   // divider side
   logic [RES_W-1:0]    div_result_i;
   logic                div_ready_i;
   logic                div_start_o;
   logic                div_signed_o;
   logic                div_annul_o;
   logic [DATA_W-1:0]   div_op1_o;
   logic [DATA_W-1:0]   div_op2_o;

   // pipeline control and architectural state
   logic                stall_req_o;
   logic [DATA_W-1:0]   hi_o;
   logic [DATA_W-1:0]   lo_o;

   // debug
   div_state_e          dbg_state_o;

   modport slave (
      input  ex_valid_i, ex_op_i, opdata1_i, opdata2_i, flush_i,
      input  div_result_i, div_ready_i,
      output div_start_o, div_signed_o, div_annul_o, div_op1_o, div_op2_o,
      output stall_req_o, hi_o, lo_o, dbg_state_o
   );

   modport master (
      output ex_valid_i, ex_op_i, opdata1_i, opdata2_i, flush_i,
      output div_result_i, div_ready_i,
      input  div_start_o, div_signed_o, div_annul_o, div_op1_o, div_op2_o,
      input  stall_req_o, hi_o, lo_o, dbg_state_o
   );

endinterface

// File: rtl/hilo_div_ctrl_hilo_reg.sv
// ---------------------------------------------------------------------------
// hilo_reg
//   Architectural HI/LO register pair with independent write ports.
//
//   Ports:
//     clk         in   clock, rising edge
//     rst         in   asynchronous reset, active low
//     i_hi_we     in   HI write enable
//     i_hi_wdata  in   HI write data
//     i_lo_we     in   LO write enable
//     i_lo_wdata  in   LO write data
//     o_hi        out  HI register value
//     o_lo        out  LO register value
// ---------------------------------------------------------------------------
module hilo_reg
   import hilo_div_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_hi_we,
   input  logic [DATA_W-1:0] i_hi_wdata,
   input  logic              i_lo_we,
   input  logic [DATA_W-1:0] i_lo_wdata,
   output logic [DATA_W-1:0] o_hi,
   output logic [DATA_W-1:0] o_lo
);

   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         if (i_hi_we) r_hi <= i_hi_wdata;
         if (i_lo_we) r_lo <= i_lo_wdata;
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule

// File: rtl/hilo_div_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_div_ctrl
//   Sequences a multi-cycle divide for the EX stage and owns HI/LO.
//   IDLE accepts DIV/DIVU (operands latched, stall raised) and performs
//   MTHI/MTLO directly. BUSY keeps the divider started and the pipeline
//   stalled until div_ready_i, capturing the result into a staging
//   register. DONE releases the stall and the divider and commits the
//   staged {remainder, quotient} into HI/LO at the edge. A flush in BUSY
//   annuls the divide; a flush in DONE suppresses the commit.
//
//   Ports:
//     clk   in      clock, rising edge
//     rst   in      asynchronous reset, active low
//     bus   slave   hilo_div_ctrl_if (EX request, divider handshake,
//                   stall request, HI/LO, debug state)
// ---------------------------------------------------------------------------
module hilo_div_ctrl
   import hilo_div_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   hilo_div_ctrl_if.slave bus
);

   div_state_e        r_state;
   logic [DATA_W-1:0] r_op1;
   logic [DATA_W-1:0] r_op2;
   logic              r_signed;
   logic [RES_W-1:0]  r_stage;

   logic              w_idle;
   logic              w_busy;
   logic              w_done;
   logic              w_take;
   logic              w_accept;
   logic              w_mthi;
   logic              w_mtlo;
   logic              w_commit;
   logic              w_hi_we;
   logic              w_lo_we;
   logic [DATA_W-1:0] w_hi_wdata;
   logic [DATA_W-1:0] w_lo_wdata;

   assign w_idle = (r_state == ST_IDLE);
   assign w_busy = (r_state == ST_BUSY);
   assign w_done = (r_state == ST_DONE);

   // rst is folded in so that a DIV sitting in EX during reset cannot
   // raise the (combinational) stall request while the block is held.
   assign w_take   = rst & w_idle & bus.ex_valid_i & ~bus.flush_i;
   assign w_accept = w_take & is_div_op(bus.ex_op_i);
   assign w_mthi   = w_take & (bus.ex_op_i == MD_MTHI);
   assign w_mtlo   = w_take & (bus.ex_op_i == MD_MTLO);

   // A flush in DONE drops the result on the floor.
   assign w_commit = w_done & ~bus.flush_i;

   // Divider controls. A flush in BUSY drops start in the same cycle and
   // pulses annul so the divider abandons the operation immediately.
   assign bus.div_start_o  = w_busy & ~bus.flush_i;
   assign bus.div_annul_o  = w_busy &  bus.flush_i;
   assign bus.stall_req_o  = w_accept | (w_busy & ~bus.flush_i);
   assign bus.div_op1_o    = r_op1;
   assign bus.div_op2_o    = r_op2;
   assign bus.div_signed_o = r_signed;
   assign bus.dbg_state_o  = r_state;

   // ------------------------------------------------------------------
   // Controller FSM with operand latches and result staging
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_op1    <= '0;
         r_op2    <= '0;
         r_signed <= 1'b0;
         r_stage  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op1    <= bus.opdata1_i;
                  r_op2    <= bus.opdata2_i;
                  r_signed <= (bus.ex_op_i == MD_DIV);
                  r_state  <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // Operands and sign mode stay frozen: the divider re-reads
               // them at completion to fix up the result signs. Flush is
               // checked first so a coincident ready is not captured.
               if (bus.flush_i) begin
                  r_state <= ST_IDLE;
               end else if (bus.div_ready_i) begin
                  r_stage <= bus.div_result_i;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // HI/LO write selection. Commit (DONE) and MTHI/MTLO (IDLE) can never
   // coincide, so a simple priority mux is enough.
   // ------------------------------------------------------------------
   assign w_hi_we    = w_commit | w_mthi;
   assign w_lo_we    = w_commit | w_mtlo;
   assign w_hi_wdata = w_commit ? r_stage[RES_W-1:DATA_W] : bus.opdata1_i;
   assign w_lo_wdata = w_commit ? r_stage[DATA_W-1:0]     : bus.opdata1_i;

   hilo_reg u_hilo_reg (
      .clk        (clk),
      .rst        (rst),
      .i_hi_we    (w_hi_we),
      .i_hi_wdata (w_hi_wdata),
      .i_lo_we    (w_lo_we),
      .i_lo_wdata (w_lo_wdata),
      .o_hi       (bus.hi_o),
      .o_lo       (bus.lo_o)
   );

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_div_ctrl
//   Directed and randomized stimulus for hilo_div_ctrl. A small divider
//   model answers div_start_o after a programmable number of cycles;
//   expected HI/LO values come from plain arithmetic on the operands the
//   bench issued, queued in exp_q until the divide completes or dies.
// ---------------------------------------------------------------------------
module tb_hilo_div_ctrl;
   import hilo_div_ctrl_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hilo_div_ctrl_if bus ();

   hilo_div_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- scoreboard state ----------------
   int          checks   = 0;
   int          failures = 0;
   int          div_lat  = 16;
   int          div_cnt  = 0;
   logic [31:0] exp_hi   = '0;
   logic [31:0] exp_lo   = '0;
   logic [63:0] exp_q[$];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference arithmetic ----------------
   // {remainder, quotient}; quotient truncates toward zero and the
   // remainder follows the dividend's sign. Divide by zero yields zeros.
   function automatic logic [63:0] div_ref(input logic sgn,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      if (b == 32'h0) return 64'h0;
      if (sgn) begin
         sa = $signed(a);
         sb = $signed(b);
      end else begin
         sa = longint'({32'h0, a});
         sb = longint'({32'h0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // ---------------- checkers ----------------
   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_hilo(input string tag);
      chk32({tag, "/hi"}, bus.hi_o, exp_hi);
      chk32({tag, "/lo"}, bus.lo_o, exp_lo);
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_ex(input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic fl);
      bus.ex_valid_i = v;
      bus.ex_op_i    = op;
      bus.opdata1_i  = a;
      bus.opdata2_i  = b;
      bus.flush_i    = fl;
   endtask

   // Divider model: answers after div_lat cycles of continuous start and
   // keeps answering until start drops. Garbage on the result bus otherwise.
   task automatic drive_div();
      bus.div_ready_i  = (div_cnt >= div_lat);
      bus.div_result_i = bus.div_ready_i ?
                         div_ref(bus.div_signed_o, bus.div_op1_o, bus.div_op2_o) :
                         {$urandom, $urandom};
   endtask

   task automatic end_cycle();
      if (bus.div_start_o === 1'b1) div_cnt++;
      else div_cnt = 0;
      @(posedge clk);
      #1;
   endtask

   // mode: 0 normal, 1 flush in BUSY cycle n, 2 flush in DONE,
   //       3 flush together with div_ready_i
   task automatic run_div(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int mode, input int n);
      logic        sgn;
      logic        fl;
      logic        aborted;
      logic [63:0] res;
      sgn = (op == MD_DIV);
      exp_q.push_back(div_ref(sgn, a, b));

      set_ex(1'b1, op, a, b, 1'b0);
      drive_div();
      @(negedge clk);
      chk1({tag, "/acc_stall"}, bus.stall_req_o, 1'b1);
      chk1({tag, "/acc_start"}, bus.div_start_o, 1'b0);
      end_cycle();

      aborted = 1'b0;
      for (int k = 1; k <= div_lat + 1 && !aborted; k++) begin
         fl = (mode == 1 && k == n) || (mode == 3 && k == div_lat + 1);
         bus.flush_i = fl;
         drive_div();
         @(negedge clk);
         if (fl) begin
            chk1({tag, "/fl_annul"}, bus.div_annul_o, 1'b1);
            chk1({tag, "/fl_start"}, bus.div_start_o, 1'b0);
            chk1({tag, "/fl_stall"}, bus.stall_req_o, 1'b0);
            aborted = 1'b1;
         end else begin
            chk1({tag, "/busy_start"}, bus.div_start_o, 1'b1);
            chk1({tag, "/busy_stall"}, bus.stall_req_o, 1'b1);
            if (k == 1 || k == div_lat + 1) begin
               chk1({tag, "/busy_annul"}, bus.div_annul_o, 1'b0);
               chk32({tag, "/op1"}, bus.div_op1_o, a);
               chk32({tag, "/op2"}, bus.div_op2_o, b);
               chk1({tag, "/signed"}, bus.div_signed_o, sgn);
            end
         end
         end_cycle();
      end

      res = exp_q.pop_front();
      if (aborted) begin
         set_ex(1'b0, MD_NONE, '0, '0, 1'b0);
         drive_div();
         @(negedge clk);
         chk1({tag, "/post_stall"}, bus.stall_req_o, 1'b0);
         chk1({tag, "/post_start"}, bus.div_start_o, 1'b0);
         end_cycle();
      end else begin
         bus.flush_i = (mode == 2);
         drive_div();
         @(negedge clk);
         chk1({tag, "/done_stall"}, bus.stall_req_o, 1'b0);
         chk1({tag, "/done_start"}, bus.div_start_o, 1'b0);
         chk1({tag, "/done_annul"}, bus.div_annul_o, 1'b0);
         chk_hilo({tag, "/done_old"});
         end_cycle();
         if (mode != 2) begin
            exp_hi = res[63:32];
            exp_lo = res[31:0];
         end
         set_ex(1'b0, MD_NONE, '0, '0, 1'b0);
      end
      chk_hilo({tag, "/end"});
   endtask

   // Single-cycle IDLE operation (MTHI/MTLO, flushed or invalid requests).
   task automatic run_one(input string tag, input logic v, input logic [2:0] op,
                          input logic [31:0] a, input logic fl);
      set_ex(v, op, a, $urandom, fl);
      drive_div();
      @(negedge clk);
      chk1({tag, "/stall"}, bus.stall_req_o, 1'b0);
      end_cycle();
      if (v && !fl) begin
         if (op == MD_MTHI) exp_hi = a;
         if (op == MD_MTLO) exp_lo = a;
      end
      set_ex(1'b0, MD_NONE, '0, '0, 1'b0);
      #1;
      chk1({tag, "/no_start"}, bus.div_start_o, 1'b0);
      chk_hilo(tag);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      // reset held with a live DIV request in EX
      rst = 1'b0;
      set_ex(1'b1, MD_DIV, 32'hDEAD_BEEF, 32'h3, 1'b0);
      bus.div_ready_i  = 1'b1;
      bus.div_result_i = {$urandom, $urandom};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("rst/stall", bus.stall_req_o, 1'b0);
      chk1("rst/start", bus.div_start_o, 1'b0);
      chk1("rst/annul", bus.div_annul_o, 1'b0);
      chk1("rst/signed", bus.div_signed_o, 1'b0);
      chk32("rst/op1", bus.div_op1_o, 32'h0);
      chk32("rst/op2", bus.div_op2_o, 32'h0);
      chk_hilo("rst");
      @(posedge clk);
      #1;
      rst = 1'b1;
      div_cnt = 0;

      // signed -7 / 2, accepted on the first edge after reset release
      div_lat = 16;
      run_div("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
      chk32("div_neg/lo_const", bus.lo_o, 32'hFFFF_FFFD);
      chk32("div_neg/hi_const", bus.hi_o, 32'hFFFF_FFFF);

      // unsigned 100 / 7
      run_div("divu_100_7", MD_DIVU, 32'd100, 32'd7, 0, 0);
      chk32("divu_100_7/lo_const", bus.lo_o, 32'd14);
      chk32("divu_100_7/hi_const", bus.hi_o, 32'd2);

      // divide by zero commits zeros over preset HI/LO
      run_one("mthi_1234", 1'b1, MD_MTHI, 32'h1234, 1'b0);
      run_one("mtlo_5678", 1'b1, MD_MTLO, 32'h5678, 1'b0);
      run_div("div_by0", MD_DIV, 32'd55, 32'd0, 0, 0);
      chk32("div_by0/hi_const", bus.hi_o, 32'h0);
      chk32("div_by0/lo_const", bus.lo_o, 32'h0);

      // flush in the 10th BUSY cycle, then a clean 9 / 3
      run_one("mthi_cafe", 1'b1, MD_MTHI, 32'hCAFE, 1'b0);
      run_one("mtlo_beef", 1'b1, MD_MTLO, 32'hBEEF, 1'b0);
      run_div("flush_busy", MD_DIVU, 32'd100, 32'd7, 1, 10);
      chk32("flush_busy/hi_const", bus.hi_o, 32'hCAFE);
      chk32("flush_busy/lo_const", bus.lo_o, 32'hBEEF);
      run_div("divu_9_3", MD_DIVU, 32'd9, 32'd3, 0, 0);
      chk32("divu_9_3/lo_const", bus.lo_o, 32'd3);
      chk32("divu_9_3/hi_const", bus.hi_o, 32'd0);

      // flush coincident with ready, and flush in DONE
      run_one("mthi_1111", 1'b1, MD_MTHI, 32'h1111_1111, 1'b0);
      run_one("mtlo_2222", 1'b1, MD_MTLO, 32'h2222_2222, 1'b0);
      run_div("flush_rdy", MD_DIVU, 32'd1000, 32'd33, 3, 0);
      run_div("flush_done", MD_DIV, 32'hFFFF_FC18, 32'd33, 2, 0);
      chk32("flush_done/hi_const", bus.hi_o, 32'h1111_1111);
      chk32("flush_done/lo_const", bus.lo_o, 32'h2222_2222);

      // IDLE flush blocks both a divide accept and an MT write
      run_one("idle_fl_div", 1'b1, MD_DIV, 32'd50, 1'b1);
      run_one("idle_fl_mthi", 1'b1, MD_MTHI, 32'h9999, 1'b1);

      // randomized mix
      for (int i = 0; i < 30; i++) begin
         rop = 3'($urandom_range(0, 4));
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom_range(1, 1000);
         if ($urandom_range(0, 1) == 1) rb = $urandom;
         case ($urandom_range(0, 5))
            0: begin
               div_lat = $urandom_range(1, 12);
               run_div("rnd_div", MD_DIV, ra, rb, 0, 0);
            end
            1: begin
               div_lat = $urandom_range(1, 12);
               run_div("rnd_divu", MD_DIVU, ra, rb, 0, 0);
            end
            2: run_one("rnd_mthi", 1'b1, MD_MTHI, ra, 1'b0);
            3: run_one("rnd_mtlo", 1'b1, MD_MTLO, ra, 1'b0);
            4: run_one("rnd_idle_fl", 1'b1, rop, ra, 1'b1);
            default: run_one("rnd_invalid", 1'b0, rop, ra, 1'b0);
         endcase
      end

      // asynchronous reset in the middle of a divide
      run_one("pre_rst_hi", 1'b1, MD_MTHI, 32'h7777_0001, 1'b0);
      div_lat = 16;
      set_ex(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0);
      drive_div();
      end_cycle();
      for (int k = 0; k < 3; k++) begin
         drive_div();
         end_cycle();
      end
      chk1("mid_busy/start", bus.div_start_o, 1'b1);
      rst = 1'b0;
      #1;
      exp_hi  = '0;
      exp_lo  = '0;
      div_cnt = 0;
      chk1("arst/stall", bus.stall_req_o, 1'b0);
      chk1("arst/start", bus.div_start_o, 1'b0);
      chk1("arst/signed", bus.div_signed_o, 1'b0);
      chk32("arst/op1", bus.div_op1_o, 32'h0);
      chk32("arst/op2", bus.div_op2_o, 32'h0);
      chk_hilo("arst");
      @(posedge clk);
      #1;
      rst = 1'b1;
      run_one("post_rst_mtlo", 1'b1, MD_MTLO, 32'hA5A5_A5A5, 1'b0);
      chk32("post_rst_mtlo/lo_const", bus.lo_o, 32'hA5A5_A5A5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
